// File: rtl/upb_rr_input_arbiter_if.sv
// AXI-Stream packet bus shared by the four arbiter inputs and the demux-facing output.
// Receivers never see tuser_in_port; the arbiter generates it on its output side.
interface upb_rr_input_arbiter_if #(
   parameter int C_AXIS_DATA_WIDTH     = 256,
   parameter int C_PACKET_LENGTH_WIDTH = 14,
   parameter int C_INPORT_WIDTH        = 3,
   parameter int C_OUTPORT_WIDTH       = 8
);
   logic [C_AXIS_DATA_WIDTH-1:0]     tdata;
   logic [C_AXIS_DATA_WIDTH/8-1:0]   tkeep;
   logic [C_PACKET_LENGTH_WIDTH-1:0] tuser_packet_length;
   logic [C_INPORT_WIDTH-1:0]        tuser_in_port;
   logic [C_INPORT_WIDTH-1:0]        tuser_in_vport;
   logic [C_OUTPORT_WIDTH-1:0]       tuser_out_port;
   logic [C_OUTPORT_WIDTH-1:0]       tuser_out_vport;
   logic                             tvalid;
   logic                             tlast;
   logic                             tready;

   modport master (
      output tdata, tkeep, tuser_packet_length, tuser_in_port, tuser_in_vport,
      output tuser_out_port, tuser_out_vport, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tuser_packet_length, tuser_in_vport,
      input  tuser_out_port, tuser_out_vport, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/upb_rr_input_arbiter.sv
// Four-input round-robin AXI-Stream packet arbiter: one input is locked for a whole
// packet, with a single IDLE arbitration cycle between consecutive packets.
module upb_rr_input_arbiter #(
   parameter int C_AXIS_DATA_WIDTH     = 256,
   parameter int C_PACKET_LENGTH_WIDTH = 14,
   parameter int C_INPORT_WIDTH        = 3,
   parameter int C_OUTPORT_WIDTH       = 8
) (
   input  logic                   axi_aclk,
   input  logic                   axi_resetn,
   upb_rr_input_arbiter_if.slave  s0_axis,
   upb_rr_input_arbiter_if.slave  s1_axis,
   upb_rr_input_arbiter_if.slave  s2_axis,
   upb_rr_input_arbiter_if.slave  s3_axis,
   upb_rr_input_arbiter_if.master m_axis,
   output logic [1:0]             grant,
   output logic [31:0]            pkt_count
);
   localparam int KW = C_AXIS_DATA_WIDTH / 8;

   typedef enum logic {ST_IDLE, ST_PASS} state_t;

   state_t      state_reg;
   logic [1:0]  grant_reg;
   logic [1:0]  last_grant_reg;
   logic [31:0] pkt_count_reg;

   logic [C_AXIS_DATA_WIDTH-1:0]     s_tdata  [4];
   logic [KW-1:0]                    s_tkeep  [4];
   logic [C_PACKET_LENGTH_WIDTH-1:0] s_len    [4];
   logic [C_INPORT_WIDTH-1:0]        s_vport  [4];
   logic [C_OUTPORT_WIDTH-1:0]       s_oport  [4];
   logic [C_OUTPORT_WIDTH-1:0]       s_ovport [4];
   logic [3:0]                       s_tvalid;
   logic [3:0]                       s_tlast;
   logic [3:0]                       s_tready;

   logic       pass;
   logic [1:0] sel;
   logic       beat_xfer;
   logic       pick_valid;
   logic [1:0] pick_port;

   // Gather the four input buses into arrays so everything below can index by port.
   assign s_tdata[0]  = s0_axis.tdata;
   assign s_tdata[1]  = s1_axis.tdata;
   assign s_tdata[2]  = s2_axis.tdata;
   assign s_tdata[3]  = s3_axis.tdata;
   assign s_tkeep[0]  = s0_axis.tkeep;
   assign s_tkeep[1]  = s1_axis.tkeep;
   assign s_tkeep[2]  = s2_axis.tkeep;
   assign s_tkeep[3]  = s3_axis.tkeep;
   assign s_len[0]    = s0_axis.tuser_packet_length;
   assign s_len[1]    = s1_axis.tuser_packet_length;
   assign s_len[2]    = s2_axis.tuser_packet_length;
   assign s_len[3]    = s3_axis.tuser_packet_length;
   assign s_vport[0]  = s0_axis.tuser_in_vport;
   assign s_vport[1]  = s1_axis.tuser_in_vport;
   assign s_vport[2]  = s2_axis.tuser_in_vport;
   assign s_vport[3]  = s3_axis.tuser_in_vport;
   assign s_oport[0]  = s0_axis.tuser_out_port;
   assign s_oport[1]  = s1_axis.tuser_out_port;
   assign s_oport[2]  = s2_axis.tuser_out_port;
   assign s_oport[3]  = s3_axis.tuser_out_port;
   assign s_ovport[0] = s0_axis.tuser_out_vport;
   assign s_ovport[1] = s1_axis.tuser_out_vport;
   assign s_ovport[2] = s2_axis.tuser_out_vport;
   assign s_ovport[3] = s3_axis.tuser_out_vport;
   assign s_tvalid    = {s3_axis.tvalid, s2_axis.tvalid, s1_axis.tvalid, s0_axis.tvalid};
   assign s_tlast     = {s3_axis.tlast, s2_axis.tlast, s1_axis.tlast, s0_axis.tlast};

   assign s0_axis.tready = s_tready[0];
   assign s1_axis.tready = s_tready[1];
   assign s2_axis.tready = s_tready[2];
   assign s3_axis.tready = s_tready[3];

   assign pass = (state_reg == ST_PASS);

   // While idle the payload mux parks on the last winner so outputs stay deterministic.
   assign sel       = pass ? grant_reg : last_grant_reg;
   assign beat_xfer = pass && s_tvalid[grant_reg] && m_axis.tready;

   assign m_axis.tdata               = s_tdata[sel];
   assign m_axis.tkeep               = s_tkeep[sel];
   assign m_axis.tuser_packet_length = s_len[sel];
   assign m_axis.tuser_in_port       = C_INPORT_WIDTH'(sel);
   assign m_axis.tuser_in_vport      = s_vport[sel];
   assign m_axis.tuser_out_port      = s_oport[sel];
   assign m_axis.tuser_out_vport     = s_ovport[sel];
   assign m_axis.tvalid              = pass && s_tvalid[grant_reg];
   assign m_axis.tlast               = s_tlast[sel];

   for (genvar gi = 0; gi < 4; gi++) begin : g_ready
      assign s_tready[gi] = pass && (grant_reg == 2'(gi)) && m_axis.tready;
   end

   // Search last_grant+1 .. last_grant+4; walking downward lets the nearest requester win.
   always_comb begin
      pick_valid = 1'b0;
      pick_port  = last_grant_reg;
      for (int k = 4; k >= 1; k--) begin
         if (s_tvalid[last_grant_reg + 2'(k)]) begin
            pick_valid = 1'b1;
            pick_port  = last_grant_reg + 2'(k);
         end
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_reg      <= ST_IDLE;
         grant_reg      <= 2'd0;
         last_grant_reg <= 2'd3;
         pkt_count_reg  <= 32'd0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_reg <= pick_port;
                  state_reg <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (beat_xfer && s_tlast[grant_reg]) begin
                  last_grant_reg <= grant_reg;
                  pkt_count_reg  <= pkt_count_reg + 32'd1;
                  state_reg      <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign grant     = grant_reg;
   assign pkt_count = pkt_count_reg;
endmodule

// File: tb/tb_upb_rr_input_arbiter.sv
// Random and directed stimulus for upb_rr_input_arbiter, checked every cycle against a
// packet-level round-robin reference model and a per-port beat scoreboard.
module tb_upb_rr_input_arbiter;
   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int LW = 14;
   localparam int IW = 3;
   localparam int OW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [LW-1:0] len;
      logic [IW-1:0] vport;
      logic [OW-1:0] oport;
      logic [OW-1:0] ovport;
      logic          last;
   } beat_t;

   typedef struct {
      int cyc;
      int port;
      bit last;
   } log_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic m_ready = 1'b1;
   always #5 clk = ~clk;

   beat_t d_beat  [4];
   logic  d_valid [4];
   logic  tr      [4];
   logic [1:0]  grant;
   logic [31:0] pkt_count;

   upb_rr_input_arbiter_if #(DW, LW, IW, OW) s0_if ();
   upb_rr_input_arbiter_if #(DW, LW, IW, OW) s1_if ();
   upb_rr_input_arbiter_if #(DW, LW, IW, OW) s2_if ();
   upb_rr_input_arbiter_if #(DW, LW, IW, OW) s3_if ();
   upb_rr_input_arbiter_if #(DW, LW, IW, OW) m_if ();

   assign {s0_if.tdata, s0_if.tkeep, s0_if.tuser_packet_length, s0_if.tuser_in_vport,
           s0_if.tuser_out_port, s0_if.tuser_out_vport, s0_if.tlast} = d_beat[0];
   assign {s1_if.tdata, s1_if.tkeep, s1_if.tuser_packet_length, s1_if.tuser_in_vport,
           s1_if.tuser_out_port, s1_if.tuser_out_vport, s1_if.tlast} = d_beat[1];
   assign {s2_if.tdata, s2_if.tkeep, s2_if.tuser_packet_length, s2_if.tuser_in_vport,
           s2_if.tuser_out_port, s2_if.tuser_out_vport, s2_if.tlast} = d_beat[2];
   assign {s3_if.tdata, s3_if.tkeep, s3_if.tuser_packet_length, s3_if.tuser_in_vport,
           s3_if.tuser_out_port, s3_if.tuser_out_vport, s3_if.tlast} = d_beat[3];
   assign s0_if.tvalid = d_valid[0];
   assign s1_if.tvalid = d_valid[1];
   assign s2_if.tvalid = d_valid[2];
   assign s3_if.tvalid = d_valid[3];
   assign s0_if.tuser_in_port = '0;
   assign s1_if.tuser_in_port = '0;
   assign s2_if.tuser_in_port = '0;
   assign s3_if.tuser_in_port = '0;
   assign tr[0] = s0_if.tready;
   assign tr[1] = s1_if.tready;
   assign tr[2] = s2_if.tready;
   assign tr[3] = s3_if.tready;
   assign m_if.tready = m_ready;

   upb_rr_input_arbiter #(
      .C_AXIS_DATA_WIDTH(DW), .C_PACKET_LENGTH_WIDTH(LW),
      .C_INPORT_WIDTH(IW), .C_OUTPORT_WIDTH(OW)
   ) dut (
      .axi_aclk(clk), .axi_resetn(rst_n),
      .s0_axis(s0_if), .s1_axis(s1_if), .s2_axis(s2_if), .s3_axis(s3_if),
      .m_axis(m_if), .grant(grant), .pkt_count(pkt_count)
   );

   int    n_checks = 0;
   int    n_err = 0;
   int    cyc = 0;
   beat_t srcq [4][$];
   beat_t sbq  [4][$];
   bit    consumed [4];
   int    vprob [4];
   bit    rand_ready = 0;
   log_t  log_q[$];

   // Reference state: owner = -1 when no port holds the output.
   int          owner = -1;
   int          lastg = 3;
   logic [31:0] model_cnt = 0;
   int          pkt_beats = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic beat_t rand_beat(input bit last);
      beat_t b;
      b.data   = {8{$urandom()}};
      b.keep   = $urandom();
      b.len    = LW'($urandom());
      b.vport  = IW'($urandom());
      b.oport  = OW'($urandom());
      b.ovport = OW'($urandom());
      b.last   = last;
      return b;
   endfunction

   task automatic add_pkt(input int port, input int nbeats);
      beat_t b;
      for (int k = 0; k < nbeats; k++) begin
         b = rand_beat(k == nbeats - 1);
         srcq[port].push_back(b);
         sbq[port].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (consumed[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
         consumed[i] = 0;
         if (srcq[i].size() > 0) begin
            d_beat[i]  = srcq[i][0];
            d_valid[i] = ($urandom_range(0, 99) < vprob[i]);
         end else begin
            d_beat[i]  = rand_beat(1'($urandom()));
            d_valid[i] = 1'b0;
         end
      end
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit busy();
      bit b = (owner >= 0);
      for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) b = 1;
      return b;
   endfunction

   task automatic wait_drain(input int limit);
      int n = 0;
      while (busy() && n < limit) begin
         step();
         n++;
      end
      chk("drain_timeout", DW'(busy()), '0);
   endtask

   task automatic clear_sources();
      for (int i = 0; i < 4; i++) begin
         srcq[i].delete();
         sbq[i].delete();
         consumed[i] = 0;
         d_valid[i]  = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, DW'(m_if.tvalid), '0);
      chk({tag, "_tready"}, DW'({tr[3], tr[2], tr[1], tr[0]}), '0);
      chk({tag, "_pkt_count"}, DW'(pkt_count), '0);
      chk({tag, "_grant"}, DW'(grant), '0);
   endtask

   // Per-cycle comparison against the reference model; the model then advances one cycle.
   always @(negedge clk) begin
      int    sel;
      bit    ev;
      bit    found;
      beat_t exp_b;
      cyc++;
      if (!rst_n) begin
         owner = -1;
         lastg = 3;
         model_cnt = 0;
         pkt_beats = 0;
         chk_reset_outputs("rst_hold");
      end else begin
         sel = (owner < 0) ? lastg : owner;
         ev  = (owner >= 0) && d_valid[owner];
         chk("m_tvalid", DW'(m_if.tvalid), DW'(ev));
         chk("m_tdata", m_if.tdata, d_beat[sel].data);
         chk("m_tkeep", DW'(m_if.tkeep), DW'(d_beat[sel].keep));
         chk("m_len", DW'(m_if.tuser_packet_length), DW'(d_beat[sel].len));
         chk("m_in_vport", DW'(m_if.tuser_in_vport), DW'(d_beat[sel].vport));
         chk("m_out_port", DW'(m_if.tuser_out_port), DW'(d_beat[sel].oport));
         chk("m_out_vport", DW'(m_if.tuser_out_vport), DW'(d_beat[sel].ovport));
         chk("pkt_count", DW'(pkt_count), DW'(model_cnt));
         for (int i = 0; i < 4; i++)
            chk($sformatf("s%0d_tready", i), DW'(tr[i]), DW'((owner == i) && m_ready));
         if (owner >= 0) begin
            chk("grant", DW'(grant), DW'(owner));
            chk("m_in_port", DW'(m_if.tuser_in_port), DW'(owner));
            chk("m_tlast", DW'(m_if.tlast), DW'(d_beat[owner].last));
         end
         if (ev && m_ready) begin
            consumed[owner] = 1;
            pkt_beats++;
            if (sbq[owner].size() == 0) begin
               chk("scoreboard_empty", DW'(owner), DW'(-1));
            end else begin
               exp_b = sbq[owner].pop_front();
               chk("order_tdata", m_if.tdata, exp_b.data);
               chk("order_tlast", DW'(m_if.tlast), DW'(exp_b.last));
            end
            log_q.push_back('{cyc: cyc, port: owner, last: d_beat[owner].last});
            if (d_beat[owner].last) begin
               model_cnt = model_cnt + 1;
               $display("pkt port=%0d beats=%0d pkt_count=%0d", owner, pkt_beats, model_cnt);
               pkt_beats = 0;
               lastg = owner;
               owner = -1;
            end
         end else if (owner < 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
               if (!found && d_valid[(lastg + k) % 4]) begin
                  owner = (lastg + k) % 4;
                  found = 1;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0, c2, cnt1;
      int lc[$];
      int lp[$];
      for (int i = 0; i < 4; i++) begin
         vprob[i] = 100;
         d_valid[i] = 1'b0;
         d_beat[i] = rand_beat(1'b0);
      end
      #1;
      chk_reset_outputs("reset");
      repeat (3) step();
      rst_n = 1'b1;

      // All four ports request at once: 0,1,2,3 with one idle cycle per 3-beat packet.
      log_q.delete();
      for (int p = 0; p < 4; p++) add_pkt(p, 3);
      wait_drain(200);
      foreach (log_q[k]) if (log_q[k].last) begin lc.push_back(log_q[k].cyc); lp.push_back(log_q[k].port); end
      chk("all4_npkts", DW'(lp.size()), DW'(4));
      for (int k = 0; k < lp.size() && k < 4; k++) chk($sformatf("all4_order%0d", k), DW'(lp[k]), DW'(k));
      for (int k = 1; k < lc.size(); k++) chk("all4_spacing", DW'(lc[k] - lc[k-1]), DW'(4));
      chk("all4_pkt_count", DW'(pkt_count), DW'(4));

      // Port 3 alone, three single-beat packets back to back.
      log_q.delete(); lc.delete(); lp.delete();
      for (int k = 0; k < 3; k++) add_pkt(3, 1);
      wait_drain(100);
      foreach (log_q[k]) begin lc.push_back(log_q[k].cyc); lp.push_back(log_q[k].port); end
      chk("p3_npkts", DW'(lp.size()), DW'(3));
      foreach (lp[k]) chk("p3_port", DW'(lp[k]), DW'(3));
      for (int k = 1; k < lc.size(); k++) chk("p3_spacing", DW'(lc[k] - lc[k-1]), DW'(2));
      chk("p3_pkt_count", DW'(pkt_count), DW'(7));

      // Port 0 requests mid-packet of port 2: it waits for tlast plus one idle cycle.
      log_q.delete();
      add_pkt(2, 5);
      n = 0;
      while (sbq[2].size() > 3 && n < 50) begin step(); n++; end
      add_pkt(0, 2);
      wait_drain(200);
      c0 = -1; c2 = -1;
      foreach (log_q[k]) begin
         if (log_q[k].port == 2 && log_q[k].last) c2 = log_q[k].cyc;
         if (log_q[k].port == 0 && c0 < 0) c0 = log_q[k].cyc;
      end
      chk("p0_after_p2", DW'(c0), DW'(c2 + 2));

      // Backpressure pattern 1,0,0,1 on a port 1 packet.
      log_q.delete();
      add_pkt(1, 5);
      n = 0;
      while (owner != 1 && n < 20) begin step(); n++; end
      step(); m_ready = 1'b1;
      step(); m_ready = 1'b0;
      step(); m_ready = 1'b0;
      step(); m_ready = 1'b1;
      wait_drain(100);
      cnt1 = 0;
      foreach (log_q[k]) if (log_q[k].port == 1) cnt1++;
      chk("bp_beats", DW'(cnt1), DW'(5));

      // Randomized traffic with bubbles, backpressure and junk on idle ports.
      rand_ready = 1;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(0, 3);
            if (srcq[n].size() < 12) add_pkt(n, $urandom_range(1, 6));
         end
         for (int i = 0; i < 4; i++) vprob[i] = $urandom_range(50, 100);
         step();
      end
      rand_ready = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) vprob[i] = 100;
      wait_drain(2000);

      // Counter wraps from all-ones to zero.
      step();
      force dut.pkt_count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_count_reg;
      model_cnt = 32'hFFFF_FFFF;
      add_pkt(2, 1);
      wait_drain(50);
      chk("wrap_pkt_count", DW'(pkt_count), '0);

      // Reset mid-packet aborts it; ports 0 and 1 together then grant port 0 first.
      add_pkt(1, 5);
      n = 0;
      while (sbq[1].size() > 3 && n < 50) begin step(); n++; end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      clear_sources();
      repeat (2) step();
      rst_n = 1'b1;
      log_q.delete();
      add_pkt(1, 2);
      add_pkt(0, 2);
      wait_drain(100);
      chk("post_rst_first", DW'(log_q.size() > 0 ? log_q[0].port : -1), '0);
      chk("post_rst_count", DW'(pkt_count), DW'(2));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/upb_rr_input_arbiter.md
UPB_RR_INPUT_ARBITER -- requirements
Module: upb_rr_input_arbiter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, SHALL be the tdata width; tkeep width = C_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_PACKET_LENGTH_WIDTH, default 14, SHALL be the tuser_packet_length width.
REQ-003 Parameter C_INPORT_WIDTH, default 3, SHALL be the width of tuser_in_port and tuser_in_vport.
REQ-004 Parameter C_OUTPORT_WIDTH, default 8, SHALL be the width of tuser_out_port and tuser_out_vport.
REQ-005 axi_aclk  in  1  sole clock; all state on rising edge.
REQ-006 axi_resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 s<i>_axis_tdata/tkeep/tuser_packet_length/tuser_in_vport/tuser_out_port/tuser_out_vport  in  widths per REQ-001..004  slave payload, i=0..3.
REQ-008 s<i>_axis_tvalid  in  1,  s<i>_axis_tlast  in  1,  s<i>_axis_tready  out  1  slave handshake, i=0..3.
REQ-009 m_axis_tdata/tkeep/tuser_packet_length/tuser_in_port/tuser_in_vport/tuser_out_port/tuser_out_vport  out  widths per REQ-001..004  master payload to the downstream demultiplexer.
REQ-010 m_axis_tvalid  out  1,  m_axis_tlast  out  1,  m_axis_tready  in  1  master handshake.
REQ-011 grant  out  2  index of the port currently granted (valid in PASS).
REQ-012 pkt_count  out  32  total packets forwarded.

Function
REQ-013 SHALL contain a two-state FSM: IDLE (no grant) and PASS (one port locked for a whole packet).
REQ-014 SHALL hold a 2-bit last_grant pointer; the round-robin search order is last_grant+1, +2, +3, +4 (mod 4).
REQ-015 In IDLE: request r[i] = s<i>_axis_tvalid; if any r set, SHALL register grant = first set port in search order and enter PASS next cycle; otherwise remain IDLE.
REQ-016 In IDLE, all s<i>_axis_tready = 0 and m_axis_tvalid = 0.
REQ-017 In PASS: m_axis_tvalid = s<grant>_axis_tvalid, m_axis_tlast = s<grant>_axis_tlast, s<grant>_axis_tready = m_axis_tready, all other s<i>_axis_tready = 0 (combinational, zero latency).
REQ-018 In PASS, m_axis payload SHALL equal s<grant> payload except m_axis_tuser_in_port = grant zero-extended to C_INPORT_WIDTH.
REQ-019 Beat transfer = m_axis_tvalid & m_axis_tready; on a transfer with m_axis_tlast = 1: last_grant <= grant, pkt_count <= pkt_count+1 (wraps 2^32-1 -> 0), FSM -> IDLE.
REQ-020 Grant SHALL NOT change mid-packet regardless of other requests; m_axis_tvalid may drop mid-packet (bubbles passed through).
REQ-021 Arbitration overhead SHALL be exactly one IDLE cycle between consecutive packets; first beat of a packet can transfer on the first PASS cycle.
REQ-022 Backpressure: while m_axis_tready = 0, no slave beat is consumed and state is unchanged.
REQ-023 Non-granted slaves' tvalid/payload SHALL have no effect on outputs.
REQ-024 Single-beat packet (tvalid & tlast on first PASS cycle) SHALL complete in one PASS cycle.
REQ-025 In IDLE, m_axis payload outputs SHALL be driven from s<last_grant> (don't-care for consumers; fixed for determinism).

Reset
REQ-026 While axi_resetn = 0: FSM = IDLE, last_grant = 3 (port 0 first), grant = 0, pkt_count = 0, m_axis_tvalid = 0, all s<i>_axis_tready = 0.
REQ-027 Reset asserted mid-packet SHALL abort the packet; after release the arbiter restarts from IDLE with no residual lock.

Verification
REQ-028 All four ports request simultaneously, each a 3-beat packet, m_axis_tready = 1 -> output order ports 0,1,2,3, tuser_in_port 0,1,2,3, 4 cycles per packet, pkt_count = 4.
REQ-029 Port 2 sends 5-beat packet; port 0 asserts tvalid at beat 2 -> port 0 stalled (tready 0) until port 2 tlast, then granted after one IDLE cycle.
REQ-030 m_axis_tready toggled 1,0,0,1 during a packet from port 1 -> beats neither lost nor duplicated; s1_axis_tready mirrors m_axis_tready.
REQ-031 Only port 3 requests, three back-to-back 1-beat packets -> each granted to port 3, one IDLE cycle between, pkt_count = 3.
REQ-032 axi_resetn pulsed low at beat 2 of a port 1 packet -> all tready/tvalid 0 immediately, pkt_count = 0; next request from port 1 and 0 together grants port 0.
REQ-033 pkt_count preloaded via force to 32'hFFFFFFFF, one packet completes -> pkt_count = 0.
